mine_field_gen: RTL and testbench
=================================

# mine_field_gen

Sequential minefield generator feeding the minesweeper game logic and the colour decoder. On `start` it places exactly `bombas` mines at pseudo-random distinct cells of the 8×8 board. It then computes each safe cell's neighbour-mine count and presents the finished 8×8 array of 4-bit cell codes with a `ready` flag. It replaces purely combinational board generation, so every game gets a different board.

## Interface
Parameters:
- `LFSR_SEED`, 16'hACE1, non-zero reset value of the LFSR.
- `GRID_N`, 8, board side length; fixed at 8, other values are unsupported.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request to generate a new board.
- `bombas`  in  4  mine count 0..15; sampled on the accepted `start` cycle.
- `safe_x`, `safe_y`  in  3 each  protected cell; used only with `MINE_SAFE_FIRST_EN`.
- `field`  out  256  cell (x,y) code at bits [(x*8+y)*4 +: 4].
- `ready`  out  1  high while `field` holds a complete board.
- `busy`  out  1  high during generation.

## Operation
- **Cell codes:**
  - 0..8 = number of adjacent mines (8-neighbourhood, clipped at the board edges).
  - 9 = `CELL_BOMB`.
  - 10..15 are never produced.
- **LFSR:** 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances every cycle from reset, regardless of state. The candidate index is `lfsr[5:0]`: x = [5:3], y = [2:0].
- **States:** IDLE, PLACE, COUNT, DONE.
- **IDLE / DONE:**
  - `start`=1 → latch `target` = `bombas`, clear the mine bitmap, the placed counter and `field`, drop `ready`, go to PLACE.
  - `start` is ignored in PLACE and COUNT.
- **PLACE:**
  - If placed == `target`, go to COUNT with the cell pointer at 0.
  - Otherwise, if the candidate cell has no mine, set its bitmap bit and increment placed.
  - An occupied candidate is skipped; retry on the next cycle.
  - Termination is guaranteed because `target` ≤ 15 < 64.
- **COUNT:**
  - One cell per cycle, pointer 0..63 (x = ptr[5:3], y = ptr[2:0]).
  - Write `CELL_BOMB` or the popcount of in-range neighbour bitmap bits into `field`.
  - After ptr 63, go to DONE.
- **DONE:** `ready`=1. `field` is held stable until the next accepted `start`.
- `busy` = (state == PLACE or COUNT).
- **Reset mid-operation:** the board is abandoned. All state returns to reset values within the same asynchronous assertion.

## Timing
- **Reset values:** state IDLE, `field` all zeros, `ready`=0, `busy`=0, LFSR=`LFSR_SEED`, counters 0.
- **Cycle 0** = the edge where `start` is sampled high:
  - cycle 1 is the first PLACE cycle;
  - PLACE lasts `target` + (number of rejected candidates) + 1 cycles;
  - COUNT lasts exactly 64 cycles;
  - `ready` rises on the following edge.
- **Minimum latency** (`bombas`=0): `ready` high at cycle 66.
- **Field visibility:** `field` bits update only on COUNT writes and on the clear at cycle 0. Downstream logic may use `field` only while `ready`=1.

## Configuration
- `MINE_SAFE_FIRST_EN` defined:
  - PLACE also rejects candidates equal to (`safe_x`,`safe_y`), sampled with `start`.
  - That cell never holds a mine; the count of mines placed is unchanged.
- Undefined:
  - `safe_x` and `safe_y` are ignored, and any cell may hold a mine.
  - The ports remain present.

## Structure
- **Package `mine_pkg`:**
  - `GRID_N`, `CELL_BOMB` = 4'd9, `LFSR_SEED` default;
  - `typedef enum logic [1:0] {IDLE, PLACE, COUNT, DONE} gen_state_t`;
  - `typedef logic [3:0] cell_t`.
- **Sub-module `lfsr16`:** clk, reset, 16-bit state output, seed parameter. Everything else lives in `mine_field_gen`.

## Test plan
- Reset low mid-COUNT, then released → `field`=0, `ready`=0, `busy`=0, state IDLE next cycle.
- `bombas`=0, `start` pulse at cycle 0 → `ready`=1 at cycle 66; all 64 codes = 0.
- `bombas`=15 → exactly 15 cells = 9. Every other cell equals a reference-model neighbour count, and no code exceeds 9.
- Force mines at corner (0,0) only via an LFSR seed → (0,1), (1,0) and (1,1) = 1; all other cells 0; (0,0) = 9.
- `start` re-asserted during PLACE and COUNT → ignored. Board completes with the originally latched `bombas`; a later `start` in DONE clears `field` and `ready`.
- With `MINE_SAFE_FIRST_EN`, `safe`=(3,4), `bombas`=15, 50 runs with varying start times → cell (3,4) is never 9, and each board has 15 mines.

Source files
------------

// File: rtl/mine_pkg.sv
// ============================================================================
// mine_pkg
// Shared types, constants and the neighbour-count helper for the minefield
// generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mine_pkg;

  localparam int          GRID_N            = 8;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

  typedef logic [3:0] cell_t;

  localparam cell_t CELL_BOMB = 4'd9;

  typedef enum logic [1:0] {IDLE, PLACE, COUNT, DONE} gen_state_t;

  // Number of mines among the 8-neighbourhood of cell idx = {x, y}. Cells
  // outside the board contribute nothing.
  function automatic cell_t neighbour_count(input logic [63:0] bm, input logic [5:0] idx);
    cell_t      n;
    int         nx;
    int         ny;
    logic [5:0] nidx;
    n = '0;
    for (int dx = -1; dx <= 1; dx++) begin
      for (int dy = -1; dy <= 1; dy++) begin
        nx   = int'(idx[5:3]) + dx;
        ny   = int'(idx[2:0]) + dy;
        nidx = {nx[2:0], ny[2:0]};
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < GRID_N &&
            ny >= 0 && ny < GRID_N && bm[nidx]) begin
          n = n + 4'd1;
        end
      end
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// lfsr16
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11. Advances every clock
// once out of reset; holds SEED while reset is asserted.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16 #(
  parameter logic [15:0] SEED = mine_pkg::DEFAULT_LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] o_state
);

  logic [15:0] r_lfsr;
  logic        w_feedback;

  assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Shift left one bit per clock, feeding the tap XOR into bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_feedback};
    end
  end

  assign o_state = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/mine_field_gen.sv
// ============================================================================
// mine_field_gen
// Sequential 8x8 minefield generator: places `bombas` distinct mines at
// LFSR-chosen cells, then fills every cell with its neighbour-mine count
// (9 = mine) one cell per clock, and flags `ready` when the board is done.
// Optional feature macro: MINE_SAFE_FIRST_EN (keeps cell (safe_x,safe_y)
// free of mines).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mine_field_gen #(
  parameter logic [15:0] LFSR_SEED = mine_pkg::DEFAULT_LFSR_SEED,
  parameter int          GRID_N    = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   bombas,
  input  logic [2:0]   safe_x,
  input  logic [2:0]   safe_y,
  output logic [255:0] field,
  output logic         ready,
  output logic         busy
);

  import mine_pkg::gen_state_t;
  import mine_pkg::cell_t;
  import mine_pkg::CELL_BOMB;
  import mine_pkg::IDLE;
  import mine_pkg::PLACE;
  import mine_pkg::COUNT;
  import mine_pkg::DONE;
  import mine_pkg::neighbour_count;

  localparam logic [5:0] c_LAST_CELL = 6'(GRID_N * GRID_N - 1);

  gen_state_t   r_state;
  gen_state_t   w_state_nxt;
  logic [3:0]   r_target;
  logic [3:0]   r_placed;
  logic [63:0]  r_bitmap;
  logic [5:0]   r_ptr;
  logic [255:0] r_field;

  logic [15:0]  w_lfsr;
  logic [5:0]   w_cand;
  logic         w_safe_hit;
  logic         w_cand_ok;
  logic         w_accept;
  cell_t        w_cell;
  logic         w_unused_lfsr;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .o_state (w_lfsr)
  );

  assign w_cand        = w_lfsr[5:0];
  assign w_unused_lfsr = ^w_lfsr[15:6];

`ifdef MINE_SAFE_FIRST_EN
  logic [5:0] r_safe;

  // Capture the protected cell alongside the accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_safe <= '0;
    end else if (w_accept) begin
      r_safe <= {safe_x, safe_y};
    end
  end

  assign w_safe_hit = (w_cand == r_safe);
`else
  logic w_unused_safe;

  assign w_unused_safe = ^{safe_x, safe_y};
  assign w_safe_hit    = 1'b0;
`endif

  assign w_accept  = start && (r_state == IDLE || r_state == DONE);
  assign w_cand_ok = !r_bitmap[w_cand] && !w_safe_hit;
  assign w_cell    = r_bitmap[r_ptr] ? CELL_BOMB : neighbour_count(r_bitmap, r_ptr);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: start only counts in IDLE/DONE; PLACE exits once the target
  // is reached, COUNT exits after the last cell.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = PLACE;
      PLACE:      if (r_placed == r_target) w_state_nxt = COUNT;
      COUNT:      if (r_ptr == c_LAST_CELL) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Datapath: clear on accepted start, place mines, then write one cell code
  // per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_target <= '0;
      r_placed <= '0;
      r_bitmap <= '0;
      r_ptr    <= '0;
      r_field  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_target <= bombas;
            r_placed <= '0;
            r_bitmap <= '0;
            r_ptr    <= '0;
            r_field  <= '0;
          end
        end
        PLACE: begin
          r_ptr <= '0;
          if (r_placed != r_target && w_cand_ok) begin
            r_bitmap[w_cand] <= 1'b1;
            r_placed         <= r_placed + 4'd1;
          end
        end
        COUNT: begin
          r_field[{r_ptr, 2'b00} +: 4] <= w_cell;
          r_ptr                        <= r_ptr + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign field = r_field;
  assign ready = (r_state == DONE);
  assign busy  = (r_state == PLACE) || (r_state == COUNT);

endmodule

`default_nettype wire

// File: tb/tb_mine_field_gen.sv
// ============================================================================
// tb_mine_field_gen
// Directed, table-driven bench for mine_field_gen plus hand-written sequences
// for reset, start-ignore and corner-mine cases.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mine_field_gen;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   bombas = '0;
  logic [2:0]   safe_x = 3'd3;
  logic [2:0]   safe_y = 3'd4;
  logic [255:0] field;
  logic         ready;
  logic         busy;

  // Second instance whose seed puts the first PLACE candidate at (0,0).
  logic         rst2_n = 1'b0;
  logic         start2 = 1'b0;
  logic [3:0]   bombas2 = '0;
  logic [255:0] field2;
  logic         ready2;
  logic         busy2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mine_field_gen #(.LFSR_SEED(16'hACE1), .GRID_N(8)) dut (
    .clk(clk), .reset(rst_n), .start(start), .bombas(bombas),
    .safe_x(safe_x), .safe_y(safe_y), .field(field), .ready(ready), .busy(busy)
  );

  // Seed 0x5600 steps to 0xAC00 (feedback 0), whose low six bits are zero.
  mine_field_gen #(.LFSR_SEED(16'h5600), .GRID_N(8)) dut_corner (
    .clk(clk), .reset(rst2_n), .start(start2), .bombas(bombas2),
    .safe_x(3'd7), .safe_y(3'd7), .field(field2), .ready(ready2), .busy(busy2)
  );

  typedef struct {
    logic [3:0] b;
    int         exp_mines;
    int         exp_cycle;   // 0 = only a lower bound applies
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_count(input logic [63:0] bm, input int x, input int y);
    int n = 0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8)
          if (bm[(x + dx) * 8 + (y + dy)]) n++;
    return n;
  endfunction

  // Mine count plus consistency of every safe cell with a reference count.
  task automatic check_board(input string name, input logic [255:0] f, input int exp_mines);
    logic [63:0] bm;
    int mines = 0;
    int bad = 0;
    logic [3:0] c;
    for (int i = 0; i < 64; i++) begin
      c = f[i * 4 +: 4];
      bm[i] = (c == 4'd9);
      if (c == 4'd9) mines++;
    end
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        c = f[(x * 8 + y) * 4 +: 4];
        if (c != 4'd9 && int'(c) != ref_count(bm, x, y)) bad++;
      end
    check({name, " mines"}, mines, exp_mines);
    check({name, " bad_cells"}, bad, 0);
  endtask

  // Pulse start for one edge (cycle 0) then report the first cycle with
  // ready high; cycle n is the interval following edge n-1.
  task automatic run_board(input logic [3:0] b, output int cyc, output logic busy1,
                           output logic ready1, output logic [255:0] field1);
    @(negedge clk);
    start = 1'b1;
    bombas = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy1 = busy;
    ready1 = ready;
    field1 = field;
    cyc = 0;
    for (int n = 1; n <= 800; n++) begin
      if (ready) begin
        cyc = n;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cyc;
    logic b1, r1;
    logic [255:0] f1;
    logic [255:0] hold;
    logic [255:0] exp_corner;

    vecs[0] = '{4'd0,  0,  66};
    vecs[1] = '{4'd1,  1,  0};
    vecs[2] = '{4'd5,  5,  0};
    vecs[3] = '{4'd9,  9,  0};
    vecs[4] = '{4'd15, 15, 0};
    vecs[5] = '{4'd0,  0,  66};

    // Reset values (both instances held in reset).
    start2 = 1'b1;
    bombas2 = 4'd1;
    #22;
    check("reset field", (field == '0), 1);
    check("reset ready", ready, 0);
    check("reset busy", busy, 0);

    // Release both resets; the corner instance sees start on its first edge.
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    cyc = 0;
    for (int n = 0; n < 200; n++) begin
      if (ready2) begin
        cyc = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("corner ready_timeout", cyc, 1);
    exp_corner = '0;
    exp_corner[3:0]   = 4'd9;
    exp_corner[7:4]   = 4'd1;
    exp_corner[35:32] = 4'd1;
    exp_corner[39:36] = 4'd1;
    check("corner field_match", (field2 == exp_corner), 1);
    check("corner cell00", field2[3:0], 9);
    check("corner cell11", field2[39:36], 1);

    // Table-driven boards.
    for (int i = 0; i < 6; i++) begin
      run_board(vecs[i].b, cyc, b1, r1, f1);
      check($sformatf("vec%0d busy_cycle1", i), b1, 1);
      check($sformatf("vec%0d ready_cycle1", i), r1, 0);
      check($sformatf("vec%0d cleared_cycle1", i), (f1 == '0), 1);
      if (vecs[i].exp_cycle != 0)
        check($sformatf("vec%0d ready_cycle", i), cyc, vecs[i].exp_cycle);
      else
        check($sformatf("vec%0d ready_late_enough", i), (cyc >= 66 + vecs[i].exp_mines), 1);
      check_board($sformatf("vec%0d", i), field, vecs[i].exp_mines);
      if (vecs[i].exp_mines == 0) check($sformatf("vec%0d all_zero", i), (field == '0), 1);
      check($sformatf("vec%0d busy_done", i), busy, 0);
    end

    // Field held stable in DONE.
    hold = field;
    repeat (5) @(posedge clk);
    #1;
    check("done field_stable", (field == hold), 1);
    check("done ready_held", ready, 1);

    // start re-asserted during PLACE and COUNT with a different count.
    @(negedge clk);
    start = 1'b1;
    bombas = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    bombas = 4'd12;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bombas = 4'd0;
    cyc = 0;
    for (int n = 0; n < 400; n++) begin
      if (ready) begin
        cyc = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("ignore ready_timeout", cyc, 1);
    check_board("ignore", field, 3);

    // New start in DONE clears field and ready on the next edge.
    @(negedge clk);
    start = 1'b1;
    bombas = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart ready_drop", ready, 0);
    check("restart field_clear", (field == '0), 1);
    check("restart busy", busy, 1);

    // Reset asserted mid-COUNT.
    repeat (30) @(posedge clk);
    #2;
    check("midcount busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midreset field", (field == '0), 1);
    check("midreset ready", ready, 0);
    check("midreset busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postreset busy", busy, 0);
    check("postreset ready", ready, 0);
    check("postreset field", (field == '0), 1);

`ifdef MINE_SAFE_FIRST_EN
    safe_x = 3'd3;
    safe_y = 3'd4;
    for (int r = 0; r < 50; r++) begin
      repeat ($urandom_range(0, 7)) @(posedge clk);
      run_board(4'd15, cyc, b1, r1, f1);
      check($sformatf("safe%0d ready", r), (cyc != 0), 1);
      check($sformatf("safe%0d cell34_not_bomb", r), (field[(3 * 8 + 4) * 4 +: 4] != 4'd9), 1);
      check_board($sformatf("safe%0d", r), field, 15);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
